// File: rtl/dvbs2x_tx_symb_rate_switch_ctrl.sv
// ---------------------------------------------------------------------------
// dvbs2x_tx_symb_rate_switch_ctrl
//
// Sequences a symbol rate change for the DVB-S2X TX symbol rate divider core.
// A new rate request is held until the modulator stream reaches a frame end
// (or a timeout forces the switch). The stream is then gated while the
// interpolation FIR drains. After that the divider select is updated, the
// block waits a settle interval, and the stream is released again.
//
// Only the AXIS handshake passes through this block; tdata/tlast go straight
// from the modulator to the divider core.
//
// Rate encoding: 0 = FULL, 1 = HALF, 2 = QUARTER. Codes at or above
// NUM_TX_SYMB_RATES are invalid.
// ---------------------------------------------------------------------------
module dvbs2x_tx_symb_rate_switch_ctrl #(
    parameter int unsigned                 SYMB_RATE_SEL_NB      = 2,
    parameter int unsigned                 NUM_TX_SYMB_RATES     = 3,
    parameter logic [SYMB_RATE_SEL_NB-1:0] DEFAULT_SYMB_RATE_SEL = '0,
    parameter int unsigned                 FLUSH_CYCLES          = 64,
    parameter int unsigned                 SETTLE_CYCLES         = 16,
    parameter int unsigned                 EOF_TIMEOUT           = 65535
) (
    input  logic                        clk_sample,
    input  logic                        sreset_sample_device,
    input  logic [SYMB_RATE_SEL_NB-1:0] symb_rate_sel_req,
    input  logic                        up_tvalid,
    output logic                        up_tready,
    input  logic                        up_tlast,
    output logic                        dn_tvalid,
    input  logic                        dn_tready,
    output logic [SYMB_RATE_SEL_NB-1:0] symb_rate_sel,
    output logic                        switch_busy,
    output logic                        switch_done,
    output logic                        eof_timeout_err,
    output logic                        req_invalid_err
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be at least 1");
    end

    if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
        $error("SETTLE_CYCLES must be at least 1");
    end

    if (DEFAULT_SYMB_RATE_SEL >= NUM_TX_SYMB_RATES) begin : g_bad_default_sel
        $error("DEFAULT_SYMB_RATE_SEL must be a valid rate code");
    end

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    // The FLUSH and SETTLE phases share one counter, sized for the longer of the two.
    localparam int unsigned PHASE_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES
                                                                        : SETTLE_CYCLES;
    localparam int unsigned PCNT_W    = $clog2(PHASE_MAX + 1);

    // A disabled timeout (0) still needs a legal 1-bit counter.
    localparam int unsigned TCNT_W    = (EOF_TIMEOUT == 0) ? 1 : $clog2(EOF_TIMEOUT + 1);

    localparam logic [PCNT_W-1:0] FLUSH_LAST  = PCNT_W'(FLUSH_CYCLES);
    localparam logic [PCNT_W-1:0] SETTLE_LAST = PCNT_W'(SETTLE_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_ONE    = PCNT_W'(1);
    localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(EOF_TIMEOUT);
    localparam logic [TCNT_W-1:0] TCNT_ONE    = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_MAX    = '1;

    // One extra bit lets the validity test cover NUM_TX_SYMB_RATES == 2**NB.
    localparam logic [SYMB_RATE_SEL_NB:0] NUM_RATES = (SYMB_RATE_SEL_NB + 1)'(NUM_TX_SYMB_RATES);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_EOF,
        ST_FLUSH,
        ST_SWITCH,
        ST_SETTLE
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                      state_q;
    logic [SYMB_RATE_SEL_NB-1:0] sel_q;
    logic [SYMB_RATE_SEL_NB-1:0] pend_q;
    logic [TCNT_W-1:0]           tcnt_q;
    logic [PCNT_W-1:0]           pcnt_q;
    logic                        gated_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        tmo_err_q;
    logic                        inv_err_q;

    // Next-value helpers and decoded conditions
    logic [TCNT_W-1:0]           tcnt_d;
    logic [PCNT_W-1:0]           pcnt_d;
    logic                        req_valid;
    logic                        eof_fire;
    logic                        timeout_hit;

    // -----------------------------------------------------------------------
    // Handshake gating: purely combinational, so no latency is added to the
    // stream. Reset forces both directions idle.
    // -----------------------------------------------------------------------
    assign up_tready = dn_tready & ~gated_q & ~sreset_sample_device;
    assign dn_tvalid = up_tvalid & ~gated_q & ~sreset_sample_device;

    // Decode request validity, frame end, timer expiry and counter increments
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally). A path that leaves one unassigned infers a latch.
        req_valid   = ({1'b0, symb_rate_sel_req} < NUM_RATES);
        eof_fire    = up_tvalid & up_tready & up_tlast;
        timeout_hit = (EOF_TIMEOUT != 0) && (tcnt_q == TMO_LAST);
        // The WAIT_EOF timer saturates, so a disabled timeout can never wrap.
        tcnt_d      = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + TCNT_ONE;
        pcnt_d      = pcnt_q + PCNT_ONE;
    end

    // Rate switch sequencer with registered status outputs
    always_ff @(posedge clk_sample) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers update together at the edge, whatever order the code is in.
        if (sreset_sample_device) begin
            state_q   <= ST_RUN;
            sel_q     <= DEFAULT_SYMB_RATE_SEL;
            pend_q    <= DEFAULT_SYMB_RATE_SEL;
            tcnt_q    <= '0;
            pcnt_q    <= '0;
            gated_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            inv_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                // Stream flows. Watch for a valid request that differs from
                // the active rate.
                ST_RUN: begin
                    if (!req_valid) begin
                        inv_err_q <= 1'b1;
                    end else if (symb_rate_sel_req != sel_q) begin
                        pend_q  <= symb_rate_sel_req;
                        tcnt_q  <= TCNT_ONE;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT_EOF;
                    end
                end

                // Stream still flows. Wait for the tlast beat to fire, or for
                // the timer to force the switch.
                ST_WAIT_EOF: begin
                    if (symb_rate_sel_req == sel_q) begin
                        // Request withdrawn: no switch and no done pulse.
                        tcnt_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        if (req_valid && (symb_rate_sel_req != pend_q)) begin
                            pend_q <= symb_rate_sel_req;
                        end

                        // A frame end takes priority over a simultaneous timeout.
                        if (eof_fire || timeout_hit) begin
                            if (!eof_fire) begin
                                tmo_err_q <= 1'b1;
                            end
                            tcnt_q  <= '0;
                            pcnt_q  <= PCNT_ONE;
                            gated_q <= 1'b1;
                            state_q <= ST_FLUSH;
                        end else begin
                            tcnt_q <= tcnt_d;
                        end
                    end
                end

                // Gated: let the interpolation FIR drain.
                ST_FLUSH: begin
                    if (pcnt_q == FLUSH_LAST) begin
                        pcnt_q  <= '0;
                        state_q <= ST_SWITCH;
                    end else begin
                        pcnt_q <= pcnt_d;
                    end
                end

                // Gated: one cycle in which the new select is registered.
                ST_SWITCH: begin
                    sel_q   <= pend_q;
                    pcnt_q  <= PCNT_ONE;
                    state_q <= ST_SETTLE;
                end

                // Gated: give the divider time to settle on the new rate.
                ST_SETTLE: begin
                    if (pcnt_q == SETTLE_LAST) begin
                        pcnt_q  <= '0;
                        gated_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        pcnt_q <= pcnt_d;
                    end
                end

                // An illegal encoding recovers to an idle, ungated RUN.
                default: begin
                    tcnt_q  <= '0;
                    pcnt_q  <= '0;
                    gated_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign symb_rate_sel   = sel_q;
    assign switch_busy     = busy_q;
    assign switch_done     = done_q;
    assign eof_timeout_err = tmo_err_q;
    assign req_invalid_err = inv_err_q;

endmodule
